hash_table_probe: RTL and testbench

Open-addressing key/value hash table with linear probing. It is the parametrised successor of the chained hash table. It adds tombstone deletion, in-place value update on duplicate insert, a bounded probe depth, a table-wide clear, and a live occupancy count. Storage is flop-based. Each operation runs multi-cycle through an FSM and is exposed on the same op_sel/op_en/op_done/op_error command interface as the chained table.

---
 rtl/hash_table_probe.sv | 218 +++++++++++++++++++++
 tb/tb_hash_table_probe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hash_table_probe.sv
// Open-addressing key/value table with linear probing, tombstone deletion,
// bounded probe depth, table-wide clear and a live occupancy count.
module hash_table_probe #(
    parameter int    KEY_WIDTH      = 32,
    parameter int    VALUE_WIDTH    = 32,
    parameter int    TOTAL_INDEX    = 16,
    parameter int    MAX_PROBE      = 4,
    parameter string HASH_ALGORITHM = "MODULUS"
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [KEY_WIDTH-1:0]               key_in,
    input  logic [VALUE_WIDTH-1:0]             value_in,
    input  logic [1:0]                         op_sel,
    input  logic                               op_en,
    output logic [VALUE_WIDTH-1:0]             value_out,
    output logic                               op_done,
    output logic                               op_error,
    output logic [$clog2(MAX_PROBE+1)-1:0]     probe_count,
    output logic [$clog2(TOTAL_INDEX+1)-1:0]   occupancy
);
    localparam int IW  = $clog2(TOTAL_INDEX);
    localparam int PW  = $clog2(MAX_PROBE+1);
    localparam int OW  = $clog2(TOTAL_INDEX+1);
    localparam int NCH = (KEY_WIDTH + IW - 1) / IW;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_SRC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_HASH, S_PROBE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] val_q, val_d;
    logic [1:0]             op_q, op_d;
    logic [IW-1:0]          h_q, h_d;
    logic [PW-1:0]          i_q, i_d;
    logic                   free_found_q, free_found_d;
    logic [IW-1:0]          free_idx_q, free_idx_d;
    logic [TOTAL_INDEX-1:0] valid_q, valid_d;
    logic [TOTAL_INDEX-1:0] tomb_q, tomb_d;
    logic [VALUE_WIDTH-1:0] vout_q, vout_d;
    logic                   err_q, err_d;
    logic [PW-1:0]          pc_q, pc_d;
    logic [OW-1:0]          occ_q, occ_d;

    logic [KEY_WIDTH-1:0]   key_mem_q [TOTAL_INDEX];
    logic [VALUE_WIDTH-1:0] val_mem_q [TOTAL_INDEX];
    logic                   key_we, val_we;
    logic [IW-1:0]          wr_idx;

    logic [IW-1:0] h_calc;
    logic [IW-1:0] slot_idx, cand_idx;
    logic          slot_valid, slot_tomb, hit, empty, last, cand_found;

    generate
        if (HASH_ALGORITHM == "XOR_FOLD") begin : g_xor
            logic [NCH*IW-1:0] key_pad;
            always_comb begin
                key_pad = (NCH*IW)'(key_q);
                h_calc  = '0;
                for (int c = 0; c < NCH; c++) begin
                    h_calc = h_calc ^ key_pad[c*IW +: IW];
                end
            end
        end else begin : g_mod
            assign h_calc = key_q[IW-1:0];
        end
    endgenerate

    assign slot_idx   = h_q + IW'(i_q);
    assign slot_valid = valid_q[slot_idx];
    assign slot_tomb  = tomb_q[slot_idx];
    assign hit        = slot_valid && (key_mem_q[slot_idx] == key_q);
    assign empty      = !slot_valid && !slot_tomb;
    assign last       = (i_q == PW'(MAX_PROBE-1));
    // The first TOMB/EMPTY slot seen wins, including the one under the probe now.
    assign cand_found = free_found_q || !slot_valid;
    assign cand_idx   = free_found_q ? free_idx_q : slot_idx;

    always_comb begin
        state_d      = state_q;
        key_d        = key_q;
        val_d        = val_q;
        op_d         = op_q;
        h_d          = h_q;
        i_d          = i_q;
        free_found_d = free_found_q;
        free_idx_d   = free_idx_q;
        valid_d      = valid_q;
        tomb_d       = tomb_q;
        vout_d       = vout_q;
        err_d        = err_q;
        pc_d         = pc_q;
        occ_d        = occ_q;
        key_we       = 1'b0;
        val_we       = 1'b0;
        wr_idx       = slot_idx;
        unique case (state_q)
            S_IDLE: begin
                if (op_en) begin
                    key_d        = key_in;
                    val_d        = value_in;
                    op_d         = op_sel;
                    i_d          = '0;
                    free_found_d = 1'b0;
                    if (op_sel == OP_CLR) begin
                        valid_d = '0;
                        tomb_d  = '0;
                        occ_d   = '0;
                        err_d   = 1'b0;
                        pc_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HASH;
                    end
                end
            end
            S_HASH: begin
                h_d     = h_calc;
                state_d = S_PROBE;
            end
            S_PROBE: begin
                if (hit || empty || last) begin
                    state_d = S_DONE;
                    pc_d    = i_q + PW'(1);
                    err_d   = 1'b0;
                    case (op_q)
                        OP_INS: begin
                            if (hit) begin
                                val_we = 1'b1;
                            end else if (cand_found) begin
                                wr_idx            = cand_idx;
                                key_we            = 1'b1;
                                val_we            = 1'b1;
                                valid_d[cand_idx] = 1'b1;
                                tomb_d[cand_idx]  = 1'b0;
                                occ_d             = occ_q + OW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_DEL: begin
                            if (hit) begin
                                valid_d[slot_idx] = 1'b0;
                                tomb_d[slot_idx]  = 1'b1;
                                occ_d             = occ_q - OW'(1);
                            end else begin
                                err_d = 1'b1;
                            end
                        end
                        OP_SRC: begin
                            if (hit) vout_d = val_mem_q[slot_idx];
                            else     err_d  = 1'b1;
                        end
                        default: ;
                    endcase
                end else begin
                    i_d = i_q + PW'(1);
                    if (!free_found_q && !slot_valid) begin
                        free_found_d = 1'b1;
                        free_idx_d   = slot_idx;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            key_q        <= '0;
            val_q        <= '0;
            op_q         <= '0;
            h_q          <= '0;
            i_q          <= '0;
            free_found_q <= 1'b0;
            free_idx_q   <= '0;
            valid_q      <= '0;
            tomb_q       <= '0;
            vout_q       <= '0;
            err_q        <= 1'b0;
            pc_q         <= '0;
            occ_q        <= '0;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            val_q        <= val_d;
            op_q         <= op_d;
            h_q          <= h_d;
            i_q          <= i_d;
            free_found_q <= free_found_d;
            free_idx_q   <= free_idx_d;
            valid_q      <= valid_d;
            tomb_q       <= tomb_d;
            vout_q       <= vout_d;
            err_q        <= err_d;
            pc_q         <= pc_d;
            occ_q        <= occ_d;
        end
    end

    // Payload storage is deliberately unreset; slot state bits gate every read.
    always_ff @(posedge clk) begin
        if (key_we) key_mem_q[wr_idx] <= key_q;
        if (val_we) val_mem_q[wr_idx] <= val_q;
    end

    assign value_out   = vout_q;
    assign op_done     = (state_q == S_DONE);
    assign op_error    = err_q;
    assign probe_count = pc_q;
    assign occupancy   = occ_q;
endmodule

// File: tb/tb_hash_table_probe.sv
// Directed bench for hash_table_probe: 8 slots, 4-deep probe, modulus hash.
module tb_hash_table_probe;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] key_in, value_in;
    logic [1:0]  op_sel;
    logic        op_en;
    logic [31:0] value_out;
    logic        op_done, op_error;
    logic [2:0]  probe_count;
    logic [3:0]  occupancy;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] INS = 2'b00, DEL = 2'b01, SRC = 2'b10, CLR = 2'b11;

    hash_table_probe #(
        .KEY_WIDTH(32), .VALUE_WIDTH(32), .TOTAL_INDEX(8), .MAX_PROBE(4),
        .HASH_ALGORITHM("MODULUS")
    ) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .value_in(value_in),
        .op_sel(op_sel), .op_en(op_en), .value_out(value_out),
        .op_done(op_done), .op_error(op_error),
        .probe_count(probe_count), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issues one op and samples 1 ns after each edge until op_done (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] k, input logic [31:0] v,
                          output int lat, output logic err, output logic [2:0] pc,
                          output logic [31:0] vo, output logic [3:0] occ);
        @(negedge clk);
        op_sel = op; key_in = k; value_in = v; op_en = 1'b1;
        @(posedge clk); #1;
        op_en = 1'b0;
        lat = 1;
        while (!op_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        err = op_error; pc = probe_count; vo = value_out; occ = occupancy;
        if (op_done) @(posedge clk);
    endtask

    task automatic op_chk(input string tag, input logic [1:0] op, input logic [31:0] k,
                          input logic [31:0] v, input int e_pc, input logic e_err,
                          input int e_occ, output logic [31:0] vo);
        int lat; logic err; logic [2:0] pc; logic [3:0] occ;
        run_op(op, k, v, lat, err, pc, vo, occ);
        chk({tag, "_lat"}, lat, (op == CLR) ? 1 : e_pc + 2);
        chk({tag, "_err"}, err, e_err);
        chk({tag, "_pc"},  pc,  e_pc);
        chk({tag, "_occ"}, occ, e_occ);
    endtask

    initial begin
        logic [31:0] vo;
        int n_done;
        rst = 1'b0; op_en = 1'b0; op_sel = '0; key_in = '0; value_in = '0;
        #12;
        chk("rst_done", op_done, 0);
        chk("rst_err",  op_error, 0);
        chk("rst_vout", value_out, 0);
        chk("rst_pc",   probe_count, 0);
        chk("rst_occ",  occupancy, 0);
        @(negedge clk); rst = 1'b1;

        // Keys 3, 11, 19 share home slot 3 and spill into 4, 5.
        op_chk("ins3",   INS, 3,  100, 1, 0, 1, vo);
        op_chk("ins11",  INS, 11, 200, 2, 0, 2, vo);
        op_chk("ins19",  INS, 19, 300, 3, 0, 3, vo);
        op_chk("src19",  SRC, 19, 0,   3, 0, 3, vo); chk("src19_val", vo, 300);
        op_chk("upd11",  INS, 11, 222, 2, 0, 3, vo);
        op_chk("src11",  SRC, 11, 0,   2, 0, 3, vo); chk("src11_val", vo, 222);

        // Slot 4 becomes a tombstone; search skips it; insert 27 reuses it.
        op_chk("del11",  DEL, 11, 0,   2, 0, 2, vo);
        op_chk("src19b", SRC, 19, 0,   3, 0, 2, vo); chk("src19b_val", vo, 300);
        op_chk("ins27",  INS, 27, 400, 4, 0, 3, vo);
        op_chk("src27",  SRC, 27, 0,   2, 0, 3, vo); chk("src27_val", vo, 400);

        // Home 7 wraps into slots 0,1,2; then the probe window is exhausted.
        op_chk("ins7",   INS, 7,  1, 1, 0, 4, vo);
        op_chk("ins15",  INS, 15, 2, 2, 0, 5, vo);
        op_chk("ins23",  INS, 23, 3, 3, 0, 6, vo);
        op_chk("ins31",  INS, 31, 4, 4, 0, 7, vo);
        op_chk("src31",  SRC, 31, 0, 4, 0, 7, vo); chk("src31_val", vo, 4);
        op_chk("ins39",  INS, 39, 5, 4, 1, 7, vo);
        op_chk("src39",  SRC, 39, 0, 4, 1, 7, vo); chk("src39_val", vo, 4);

        op_chk("clr",    CLR, 0, 0, 0, 0, 0, vo);
        op_chk("src3c",  SRC, 3, 0, 1, 1, 0, vo); chk("src3c_val", vo, 4);
        op_chk("src5",   SRC, 5, 0, 1, 1, 0, vo);
        op_chk("del5",   DEL, 5, 0, 1, 1, 0, vo);

        // Reset while an insert of key 5 sits in PROBE: no done, no write.
        op_chk("ins3r",  INS, 3, 100, 1, 0, 1, vo);
        @(negedge clk);
        op_sel = INS; key_in = 5; value_in = 9; op_en = 1'b1;
        @(posedge clk); #1 op_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("midrst_done", op_done, 0);
        chk("midrst_occ",  occupancy, 0);
        chk("midrst_vout", value_out, 0);
        @(negedge clk); rst = 1'b1;
        n_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (op_done) n_done++;
        end
        chk("midrst_nodone", n_done, 0);
        op_chk("src5r", SRC, 5, 0, 1, 1, 0, vo);
        op_chk("src3r", SRC, 3, 0, 1, 1, 0, vo);

        // op_en held high (as a delete of key 4) while an insert is busy.
        @(negedge clk);
        op_sel = INS; key_in = 4; value_in = 55; op_en = 1'b1;
        @(posedge clk); #1;
        op_sel = DEL;
        n_done = 0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            if (op_done) n_done++;
        end
        op_en = 1'b0;
        chk("busy_done", n_done, 1);
        n_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (op_done) n_done++;
        end
        chk("busy_extra", n_done, 0);
        chk("busy_occ", occupancy, 1);
        op_chk("src4", SRC, 4, 0, 1, 0, 1, vo); chk("src4_val", vo, 55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
